// File: rtl/aurora_seq_framer.sv
// -----------------------------------------------------------------------------
// aurora_seq_framer
//
// Sequence-number framing engine between the user AXI-Stream ports and the
// Aurora core. Everything runs on m_axis_aclk.
//
// TX: frames pass through with zero latency. When enabled, a trailing word
// carrying a sequence number (local counter or echo of the last received
// sequence) is appended. The user tlast is suppressed and the trailer carries
// tlast instead.
// RX: when stripping, the last word of each frame is removed, captured as the
// received sequence number and checked against the previous one. Gaps
// accumulate into a saturating lost-frame counter.
//
// Ports
//   m_axis_aclk, reset          clock, asynchronous active-high reset
//   ctrl_seq_en/strip/echo      TX append enable, RX strip enable, TX echo mode
//   ctrl_rst_cntrs              synchronous clear of counters and sync flag
//   s_axis_tx_*                 user TX stream in (valid/ready)
//   m_axis_tx_*                 TX stream out to Aurora (valid/ready)
//   s_axis_rx_*                 RX stream from Aurora (no ready)
//   m_axis_rx_*                 RX stream to user (no ready)
//   cntr_out, cntr_in           frames sent on m_axis_tx / received on s_axis_rx
//   cntr_lost                   saturating accumulated sequence gap
//   seq_err                     one-cycle pulse on a sequence mismatch
//   rx_seq_last                 last captured RX sequence number
//   tx_state_dbg                current TX FSM state (debug)
//
// Handshake: a beat transfers on a rising edge where tvalid and tready are both
// high; a source never retracts tvalid or changes tdata/tlast while waiting
// for tready. The RX paths have no ready: every valid beat is a transfer.
// -----------------------------------------------------------------------------
module aurora_seq_framer #(
  parameter int DATA_WIDTH = 32,
  parameter int SEQ_WIDTH  = 32,
  parameter int CNTR_WIDTH = 64,
  parameter int LOST_WIDTH = 32
) (
  input  logic                  m_axis_aclk,
  input  logic                  reset,
  input  logic                  ctrl_seq_en,
  input  logic                  ctrl_seq_strip,
  input  logic                  ctrl_seq_echo,
  input  logic                  ctrl_rst_cntrs,
  input  logic                  s_axis_tx_tvalid,
  input  logic [DATA_WIDTH-1:0] s_axis_tx_tdata,
  input  logic                  s_axis_tx_tlast,
  output logic                  s_axis_tx_tready,
  output logic                  m_axis_tx_tvalid,
  output logic [DATA_WIDTH-1:0] m_axis_tx_tdata,
  output logic                  m_axis_tx_tlast,
  input  logic                  m_axis_tx_tready,
  input  logic                  s_axis_rx_tvalid,
  input  logic [DATA_WIDTH-1:0] s_axis_rx_tdata,
  input  logic                  s_axis_rx_tlast,
  output logic                  m_axis_rx_tvalid,
  output logic [DATA_WIDTH-1:0] m_axis_rx_tdata,
  output logic                  m_axis_rx_tlast,
  output logic [CNTR_WIDTH-1:0] cntr_out,
  output logic [CNTR_WIDTH-1:0] cntr_in,
  output logic [LOST_WIDTH-1:0] cntr_lost,
  output logic                  seq_err,
  output logic [SEQ_WIDTH-1:0]  rx_seq_last,
  output logic [1:0]            tx_state_dbg
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BODY = 2'd1;
  localparam logic [1:0] ST_SEQ  = 2'd2;

  localparam int SUM_W = ((LOST_WIDTH > SEQ_WIDTH) ? LOST_WIDTH : SEQ_WIDTH) + 1;
  localparam logic [LOST_WIDTH-1:0] LOST_MAX = '1;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]            state_q, state_d;
  logic                  mode_en_q, mode_en_d;
  logic                  mode_echo_q, mode_echo_d;
  logic [SEQ_WIDTH-1:0]  seq_val_q, seq_val_d;
  logic [SEQ_WIDTH-1:0]  tx_seq_q, tx_seq_d;
  logic [CNTR_WIDTH-1:0] cntr_out_q, cntr_out_d;

  logic                  rx_in_frame_q, rx_in_frame_d;
  logic                  rx_strip_q, rx_strip_d;
  logic                  hold_valid_q, hold_valid_d;
  logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;
  logic                  orx_valid_q, orx_valid_d;
  logic [DATA_WIDTH-1:0] orx_data_q, orx_data_d;
  logic                  orx_last_q, orx_last_d;
  logic [SEQ_WIDTH-1:0]  rx_seq_last_q, rx_seq_last_d;
  logic                  sync_q, sync_d;
  logic [CNTR_WIDTH-1:0] cntr_in_q, cntr_in_d;
  logic [LOST_WIDTH-1:0] cntr_lost_q, cntr_lost_d;
  logic                  seq_err_q, seq_err_d;

  // TX combinational signals
  logic                  eff_en, eff_echo;
  logic                  tx_valid, tx_ready, tx_last;
  logic [DATA_WIDTH-1:0] tx_data;

  // RX combinational signals
  logic                  eff_strip;
  logic [SEQ_WIDTH-1:0]  rx_seq_recv, rx_seq_exp, rx_gap;
  logic [SUM_W-1:0]      lost_sum;

  // ---------------------------------------------------------------------------
  // TX path
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    mode_en_d   = mode_en_q;
    mode_echo_d = mode_echo_q;
    seq_val_d   = seq_val_q;
    tx_seq_d    = tx_seq_q;
    cntr_out_d  = cntr_out_q;

    // The first beat of a frame is steered by the live controls; the latched
    // copies take over from the second beat on.
    eff_en   = (state_q == ST_IDLE) ? ctrl_seq_en   : mode_en_q;
    eff_echo = (state_q == ST_IDLE) ? ctrl_seq_echo : mode_echo_q;

    tx_valid = 1'b0;
    tx_ready = 1'b0;
    tx_last  = 1'b0;
    tx_data  = s_axis_tx_tdata;

    if (state_q == ST_SEQ) begin
      tx_valid = 1'b1;
      tx_last  = 1'b1;
      tx_data  = DATA_WIDTH'(seq_val_q);
      if (m_axis_tx_tready) begin
        state_d = ST_IDLE;
        if (!mode_echo_q) tx_seq_d = tx_seq_q + SEQ_WIDTH'(1);
      end
    end else begin
      tx_valid = s_axis_tx_tvalid;
      tx_ready = m_axis_tx_tready;
      tx_last  = eff_en ? 1'b0 : s_axis_tx_tlast;
      if (s_axis_tx_tvalid && m_axis_tx_tready) begin
        if (state_q == ST_IDLE) begin
          mode_en_d   = ctrl_seq_en;
          mode_echo_d = ctrl_seq_echo;
        end
        if (s_axis_tx_tlast) begin
          if (eff_en) begin
            state_d = ST_SEQ;
            // Register value before this edge: an RX capture on the same
            // edge is not seen by this frame.
            seq_val_d = eff_echo ? rx_seq_last_q : tx_seq_q;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_BODY;
        end
      end
    end

    if (ctrl_rst_cntrs) begin
      cntr_out_d = '0;
    end else if (tx_valid && m_axis_tx_tready && tx_last) begin
      cntr_out_d = cntr_out_q + CNTR_WIDTH'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // RX path
  // ---------------------------------------------------------------------------
  always_comb begin
    rx_in_frame_d = rx_in_frame_q;
    rx_strip_d    = rx_strip_q;
    hold_valid_d  = hold_valid_q;
    hold_data_d   = hold_data_q;
    orx_valid_d   = 1'b0;
    orx_data_d    = orx_data_q;
    orx_last_d    = 1'b0;
    rx_seq_last_d = rx_seq_last_q;
    sync_d        = sync_q;
    cntr_in_d     = cntr_in_q;
    cntr_lost_d   = cntr_lost_q;
    seq_err_d     = 1'b0;

    eff_strip   = rx_in_frame_q ? rx_strip_q : ctrl_seq_strip;
    rx_seq_recv = s_axis_rx_tdata[SEQ_WIDTH-1:0];
    rx_seq_exp  = rx_seq_last_q + SEQ_WIDTH'(1);
    rx_gap      = rx_seq_recv - rx_seq_exp;
    lost_sum    = SUM_W'(cntr_lost_q) + SUM_W'(rx_gap);

    if (s_axis_rx_tvalid) begin
      rx_strip_d    = eff_strip;
      rx_in_frame_d = !s_axis_rx_tlast;
      if (s_axis_rx_tlast) cntr_in_d = cntr_in_q + CNTR_WIDTH'(1);

      if (eff_strip) begin
        // One-word delay so the trailer can be dropped once tlast is seen.
        if (hold_valid_q) begin
          orx_valid_d = 1'b1;
          orx_data_d  = hold_data_q;
          orx_last_d  = s_axis_rx_tlast;
        end
        if (!s_axis_rx_tlast) begin
          hold_valid_d = 1'b1;
          hold_data_d  = s_axis_rx_tdata;
        end else begin
          hold_valid_d  = 1'b0;
          rx_seq_last_d = rx_seq_recv;
          sync_d        = 1'b1;
          if (sync_q && (rx_seq_recv != rx_seq_exp)) begin
            seq_err_d = 1'b1;
            // Older/duplicate sequences wrap to a large gap by design.
            cntr_lost_d = (lost_sum > SUM_W'(LOST_MAX)) ? LOST_MAX
                                                        : lost_sum[LOST_WIDTH-1:0];
          end
        end
      end else begin
        orx_valid_d = 1'b1;
        orx_data_d  = s_axis_rx_tdata;
        orx_last_d  = s_axis_rx_tlast;
      end
    end

    if (ctrl_rst_cntrs) begin
      cntr_in_d   = '0;
      cntr_lost_d = '0;
      sync_d      = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge m_axis_aclk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      mode_en_q     <= 1'b0;
      mode_echo_q   <= 1'b0;
      seq_val_q     <= '0;
      tx_seq_q      <= '0;
      cntr_out_q    <= '0;
      rx_in_frame_q <= 1'b0;
      rx_strip_q    <= 1'b0;
      hold_valid_q  <= 1'b0;
      hold_data_q   <= '0;
      orx_valid_q   <= 1'b0;
      orx_data_q    <= '0;
      orx_last_q    <= 1'b0;
      rx_seq_last_q <= '0;
      sync_q        <= 1'b0;
      cntr_in_q     <= '0;
      cntr_lost_q   <= '0;
      seq_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      mode_en_q     <= mode_en_d;
      mode_echo_q   <= mode_echo_d;
      seq_val_q     <= seq_val_d;
      tx_seq_q      <= tx_seq_d;
      cntr_out_q    <= cntr_out_d;
      rx_in_frame_q <= rx_in_frame_d;
      rx_strip_q    <= rx_strip_d;
      hold_valid_q  <= hold_valid_d;
      hold_data_q   <= hold_data_d;
      orx_valid_q   <= orx_valid_d;
      orx_data_q    <= orx_data_d;
      orx_last_q    <= orx_last_d;
      rx_seq_last_q <= rx_seq_last_d;
      sync_q        <= sync_d;
      cntr_in_q     <= cntr_in_d;
      cntr_lost_q   <= cntr_lost_d;
      seq_err_q     <= seq_err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // The TX pass-through is combinational, so reset gates it directly to keep
  // m_axis_tx_tvalid low for the whole time reset is asserted.
  assign m_axis_tx_tvalid = tx_valid & ~reset;
  assign s_axis_tx_tready = tx_ready & ~reset;
  assign m_axis_tx_tdata  = tx_data;
  assign m_axis_tx_tlast  = tx_last;

  assign m_axis_rx_tvalid = orx_valid_q;
  assign m_axis_rx_tdata  = orx_data_q;
  assign m_axis_rx_tlast  = orx_last_q;

  assign cntr_out     = cntr_out_q;
  assign cntr_in      = cntr_in_q;
  assign cntr_lost    = cntr_lost_q;
  assign seq_err      = seq_err_q;
  assign rx_seq_last  = rx_seq_last_q;
  assign tx_state_dbg = state_q;

endmodule

// File: tb/tb_aurora_seq_framer.sv
// -----------------------------------------------------------------------------
// tb_aurora_seq_framer
//
// Main instance: DATA 32, SEQ 16, counters 16 bits. Expected TX/RX beats are
// queued by the drivers from frame-level rules and checked by one monitor on
// every falling edge. Counters and sequence state are tracked by a small
// frame-level model. A second instance (DATA 8, SEQ 4, LOST 4) covers wrap
// and saturation with hand-computed values.
// -----------------------------------------------------------------------------
module tb_aurora_seq_framer;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk;
  logic reset;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Main DUT signals
  // ---------------------------------------------------------------------------
  logic        ctrl_seq_en, ctrl_seq_strip, ctrl_seq_echo, ctrl_rst_cntrs;
  logic        s_axis_tx_tvalid, s_axis_tx_tlast, s_axis_tx_tready;
  logic [31:0] s_axis_tx_tdata;
  logic        m_axis_tx_tvalid, m_axis_tx_tlast, m_axis_tx_tready;
  logic [31:0] m_axis_tx_tdata;
  logic        s_axis_rx_tvalid, s_axis_rx_tlast;
  logic [31:0] s_axis_rx_tdata;
  logic        m_axis_rx_tvalid, m_axis_rx_tlast;
  logic [31:0] m_axis_rx_tdata;
  logic [15:0] cntr_out, cntr_in, cntr_lost;
  logic        seq_err;
  logic [15:0] rx_seq_last;
  logic [1:0]  tx_state_dbg;

  aurora_seq_framer #(
    .DATA_WIDTH(32), .SEQ_WIDTH(16), .CNTR_WIDTH(16), .LOST_WIDTH(16)
  ) u_dut (
    .m_axis_aclk      (clk),
    .reset            (reset),
    .ctrl_seq_en      (ctrl_seq_en),
    .ctrl_seq_strip   (ctrl_seq_strip),
    .ctrl_seq_echo    (ctrl_seq_echo),
    .ctrl_rst_cntrs   (ctrl_rst_cntrs),
    .s_axis_tx_tvalid (s_axis_tx_tvalid),
    .s_axis_tx_tdata  (s_axis_tx_tdata),
    .s_axis_tx_tlast  (s_axis_tx_tlast),
    .s_axis_tx_tready (s_axis_tx_tready),
    .m_axis_tx_tvalid (m_axis_tx_tvalid),
    .m_axis_tx_tdata  (m_axis_tx_tdata),
    .m_axis_tx_tlast  (m_axis_tx_tlast),
    .m_axis_tx_tready (m_axis_tx_tready),
    .s_axis_rx_tvalid (s_axis_rx_tvalid),
    .s_axis_rx_tdata  (s_axis_rx_tdata),
    .s_axis_rx_tlast  (s_axis_rx_tlast),
    .m_axis_rx_tvalid (m_axis_rx_tvalid),
    .m_axis_rx_tdata  (m_axis_rx_tdata),
    .m_axis_rx_tlast  (m_axis_rx_tlast),
    .cntr_out         (cntr_out),
    .cntr_in          (cntr_in),
    .cntr_lost        (cntr_lost),
    .seq_err          (seq_err),
    .rx_seq_last      (rx_seq_last),
    .tx_state_dbg     (tx_state_dbg)
  );

  // ---------------------------------------------------------------------------
  // Small DUT (wrap / saturation)
  // ---------------------------------------------------------------------------
  logic       sm_rx_tvalid, sm_rx_tlast;
  logic [7:0] sm_rx_tdata;
  logic       sm_tx_s_ready, sm_tx_m_valid, sm_tx_m_last;
  logic [7:0] sm_tx_m_data;
  logic       sm_rx_m_valid, sm_rx_m_last;
  logic [7:0] sm_rx_m_data;
  logic [7:0] sm_cntr_out, sm_cntr_in;
  logic [3:0] sm_cntr_lost, sm_rx_seq_last;
  logic       sm_seq_err;
  logic [1:0] sm_state_dbg;

  aurora_seq_framer #(
    .DATA_WIDTH(8), .SEQ_WIDTH(4), .CNTR_WIDTH(8), .LOST_WIDTH(4)
  ) u_small (
    .m_axis_aclk      (clk),
    .reset            (reset),
    .ctrl_seq_en      (1'b0),
    .ctrl_seq_strip   (1'b1),
    .ctrl_seq_echo    (1'b0),
    .ctrl_rst_cntrs   (1'b0),
    .s_axis_tx_tvalid (1'b0),
    .s_axis_tx_tdata  (8'h00),
    .s_axis_tx_tlast  (1'b0),
    .s_axis_tx_tready (sm_tx_s_ready),
    .m_axis_tx_tvalid (sm_tx_m_valid),
    .m_axis_tx_tdata  (sm_tx_m_data),
    .m_axis_tx_tlast  (sm_tx_m_last),
    .m_axis_tx_tready (1'b1),
    .s_axis_rx_tvalid (sm_rx_tvalid),
    .s_axis_rx_tdata  (sm_rx_tdata),
    .s_axis_rx_tlast  (sm_rx_tlast),
    .m_axis_rx_tvalid (sm_rx_m_valid),
    .m_axis_rx_tdata  (sm_rx_m_data),
    .m_axis_rx_tlast  (sm_rx_m_last),
    .cntr_out         (sm_cntr_out),
    .cntr_in          (sm_cntr_in),
    .cntr_lost        (sm_cntr_lost),
    .seq_err          (sm_seq_err),
    .rx_seq_last      (sm_rx_seq_last),
    .tx_state_dbg     (sm_state_dbg)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard and model state
  // ---------------------------------------------------------------------------
  logic [32:0] tx_exp_q[$];   // {tlast, tdata}
  logic [32:0] rx_exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          seen_err = 0;
  logic [31:0] last_trailer = '0;

  logic [15:0] m_tx_seq, m_rsl, m_lost;
  bit          m_sync;
  int          m_cntr_out, m_cntr_in, m_err;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_tx_seq = '0; m_rsl = '0; m_lost = '0; m_sync = 1'b0;
    m_cntr_out = 0; m_cntr_in = 0;
  endtask

  task automatic model_clear();
    m_lost = '0; m_sync = 1'b0; m_cntr_out = 0; m_cntr_in = 0;
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: every falling edge, outside reset
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    logic [32:0] e;
    if (!reset) begin
      if (m_axis_tx_tvalid && m_axis_tx_tready) begin
        if (tx_exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL tx_unexpected: got=%0h expected=none", {m_axis_tx_tlast, m_axis_tx_tdata});
        end else begin
          e = tx_exp_q.pop_front();
          check("tx_beat", {m_axis_tx_tlast, m_axis_tx_tdata}, e);
          if (m_axis_tx_tlast) last_trailer = m_axis_tx_tdata;
        end
      end
      if (m_axis_rx_tvalid) begin
        if (rx_exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rx_unexpected: got=%0h expected=none", {m_axis_rx_tlast, m_axis_rx_tdata});
        end else begin
          e = rx_exp_q.pop_front();
          check("rx_beat", {m_axis_rx_tlast, m_axis_rx_tdata}, e);
        end
      end
      if (seq_err) seen_err++;
    end
  end

  // ---------------------------------------------------------------------------
  // Drivers (all enter and leave at posedge + 1)
  // ---------------------------------------------------------------------------
  task automatic tx_beat(input logic [31:0] d, input bit last, input bit en);
    int n;
    s_axis_tx_tvalid = 1'b1;
    s_axis_tx_tdata  = d;
    s_axis_tx_tlast  = last;
    tx_exp_q.push_back({(en ? 1'b0 : last), d});
    n = 0;
    forever begin
      @(negedge clk);
      if (s_axis_tx_tready) break;
      n++;
      if (n > 200) begin
        check("tx_ready_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  // flip: invert the controls after the first beat; the frame must keep the
  // mode it started with.
  task automatic tx_frame(input int n, input logic [31:0] base, input bit en,
                          input bit echo, input bit flip);
    logic [15:0] tr;
    ctrl_seq_en   = en;
    ctrl_seq_echo = echo;
    for (int i = 0; i < n; i++) begin
      tx_beat(base + 32'(i), (i == n - 1), en);
      if (flip && i == 0) begin
        ctrl_seq_en   = !en;
        ctrl_seq_echo = !echo;
      end
    end
    s_axis_tx_tvalid = 1'b0;
    s_axis_tx_tlast  = 1'b0;
    if (en) begin
      tr = echo ? m_rsl : m_tx_seq;
      if (!echo) m_tx_seq = m_tx_seq + 16'd1;
      tx_exp_q.push_back({1'b1, 16'h0000, tr});
    end
    m_cntr_out++;
    ctrl_seq_en   = 1'b0;
    ctrl_seq_echo = 1'b0;
  endtask

  task automatic rx_frame(input int n, input logic [31:0] base, input logic [31:0] seq,
                          input bit strip);
    logic [15:0] recv, gap;
    logic [16:0] sum;
    ctrl_seq_strip = strip;
    for (int i = 0; i < n; i++) begin
      if (strip) begin
        if (i < n - 1) rx_exp_q.push_back({(i == n - 2), base + 32'(i)});
      end else begin
        rx_exp_q.push_back({(i == n - 1), (i == n - 1) ? seq : base + 32'(i)});
      end
    end
    for (int i = 0; i < n; i++) begin
      s_axis_rx_tvalid = 1'b1;
      s_axis_rx_tlast  = (i == n - 1);
      s_axis_rx_tdata  = (i == n - 1) ? seq : base + 32'(i);
      @(posedge clk); #1;
    end
    s_axis_rx_tvalid = 1'b0;
    s_axis_rx_tlast  = 1'b0;
    m_cntr_in++;
    if (strip) begin
      recv = seq[15:0];
      if (m_sync && recv != m_rsl + 16'd1) begin
        m_err++;
        gap    = recv - (m_rsl + 16'd1);
        sum    = {1'b0, m_lost} + {1'b0, gap};
        m_lost = sum[16] ? 16'hFFFF : sum[15:0];
      end
      m_rsl  = recv;
      m_sync = 1'b1;
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((tx_exp_q.size() != 0 || rx_exp_q.size() != 0) && n < 300) begin
      @(posedge clk); n++;
    end
    repeat (3) @(posedge clk);
    #1;
    check("drain_tx", tx_exp_q.size(), 0);
    check("drain_rx", rx_exp_q.size(), 0);
  endtask

  task automatic check_model(input string tag);
    check({tag, "_cntr_out"},    cntr_out,    m_cntr_out[15:0]);
    check({tag, "_cntr_in"},     cntr_in,     m_cntr_in[15:0]);
    check({tag, "_cntr_lost"},   cntr_lost,   m_lost);
    check({tag, "_rx_seq_last"}, rx_seq_last, m_rsl);
    check({tag, "_seq_errs"},    seen_err,    m_err);
  endtask

  task automatic sm_rx(input logic [3:0] seq, output logic err);
    sm_rx_tvalid = 1'b1;
    sm_rx_tlast  = 1'b1;
    sm_rx_tdata  = {4'h0, seq};
    @(posedge clk); #1;
    sm_rx_tvalid = 1'b0;
    sm_rx_tlast  = 1'b0;
    @(negedge clk);
    err = sm_seq_err;
    @(posedge clk); #1;
  endtask

  // ---------------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------------
  initial begin
    #1000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic e;
    reset = 1'b1;
    ctrl_seq_en = 0; ctrl_seq_strip = 0; ctrl_seq_echo = 0; ctrl_rst_cntrs = 0;
    s_axis_tx_tvalid = 0; s_axis_tx_tdata = '0; s_axis_tx_tlast = 0;
    m_axis_tx_tready = 1;
    s_axis_rx_tvalid = 0; s_axis_rx_tdata = '0; s_axis_rx_tlast = 0;
    sm_rx_tvalid = 0; sm_rx_tdata = '0; sm_rx_tlast = 0;
    m_err = 0;
    model_reset();

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_m_tx_tvalid", m_axis_tx_tvalid, 0);
    check("rst_m_rx_tvalid", m_axis_rx_tvalid, 0);
    check("rst_cntr_out",    cntr_out, 0);
    check("rst_cntr_in",     cntr_in, 0);
    check("rst_cntr_lost",   cntr_lost, 0);
    check("rst_seq_err",     seq_err, 0);
    check("rst_rx_seq_last", rx_seq_last, 0);
    check("rst_state",       tx_state_dbg, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Append: three 4-word frames -> trailers 0, 1, 2
    for (int f = 0; f < 3; f++) begin
      tx_frame(4, 32'h100 * (f + 1), 1, 0, 0);
      wait_drain();
      check("append_trailer", last_trailer, f);
    end
    check("append_cntr_out", cntr_out, 3);

    // Backpressure during the trailer
    tx_frame(4, 32'h400, 1, 0, 0);
    m_axis_tx_tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", m_axis_tx_tvalid, 1);
      check("bp_data",  m_axis_tx_tdata, 32'h3);
      check("bp_last",  m_axis_tx_tlast, 1);
      check("bp_s_ready", s_axis_tx_tready, 0);
    end
    @(posedge clk); #1;
    m_axis_tx_tready = 1'b1;
    wait_drain();
    check("bp_trailer", last_trailer, 32'h3);
    check("bp_cntr_out", cntr_out, 4);

    // Controls changed mid-frame have no effect; then a pass-through frame
    tx_frame(3, 32'h500, 1, 0, 1);
    wait_drain();
    check("latch_trailer", last_trailer, 32'h4);
    tx_frame(2, 32'h600, 0, 0, 0);
    wait_drain();
    check("pass_cntr_out", cntr_out, 6);

    // Strip and gap: 10, 11, 14
    rx_frame(3, 32'h1000, 32'd10, 1);
    rx_frame(2, 32'h2000, 32'd11, 1);
    rx_frame(4, 32'h3000, 32'd14, 1);
    wait_drain();
    check("gap_seq_errs", seen_err, 1);
    check("gap_cntr_lost", cntr_lost, 2);
    check("gap_cntr_in", cntr_in, 3);
    check("gap_rx_seq_last", rx_seq_last, 14);
    // Single-beat frame (emits nothing) and an RX pass-through frame
    rx_frame(1, 32'h0, 32'd15, 1);
    rx_frame(3, 32'h4000, 32'hDEAD, 0);
    wait_drain();
    check_model("rx_misc");

    // Clear pulse
    ctrl_rst_cntrs = 1'b1;
    @(posedge clk); #1;
    ctrl_rst_cntrs = 1'b0;
    model_clear();
    check_model("clear");

    // Echo: upper bits of the RX word are not part of the sequence
    rx_frame(2, 32'h5000, 32'hABCD1234, 1);
    tx_frame(2, 32'h700, 1, 1, 0);
    wait_drain();
    check("echo_trailer", last_trailer, 32'h00001234);
    tx_frame(1, 32'h800, 1, 0, 0);
    wait_drain();
    check("echo_tx_seq_kept", last_trailer, 32'h5);
    check_model("echo");

    // Clear held while RX and TX frames complete
    ctrl_rst_cntrs = 1'b1;
    rx_frame(2, 32'h6000, 32'h1235, 1);
    tx_frame(2, 32'h900, 1, 0, 0);
    wait_drain();
    ctrl_rst_cntrs = 1'b0;
    model_clear();
    check("clr_cntr_out", cntr_out, 0);
    check("clr_cntr_in", cntr_in, 0);
    check("clr_cntr_lost", cntr_lost, 0);
    check_model("clr");

    // Reset mid-frame: no trailer, tvalid low at once
    ctrl_seq_en = 1'b1;
    tx_beat(32'hA00, 0, 1);
    tx_beat(32'hA01, 0, 1);
    s_axis_tx_tdata = 32'hA02;
    reset = 1'b1;
    @(negedge clk);
    check("midrst_m_valid", m_axis_tx_tvalid, 0);
    check("midrst_s_ready", s_axis_tx_tready, 0);
    s_axis_tx_tvalid = 1'b0;
    ctrl_seq_en = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    repeat (4) @(posedge clk);
    #1;
    check_model("midrst");
    tx_frame(2, 32'hB00, 1, 0, 0);
    wait_drain();
    check("midrst_trailer", last_trailer, 32'h0);

    // Small instance: wrap 15 -> 0, then 0/5 alternation into saturation
    sm_rx(4'd15, e);
    check("sm_first_err", e, 0);
    check("sm_first_seq", sm_rx_seq_last, 15);
    sm_rx(4'd0, e);
    check("sm_wrap_err", e, 0);
    check("sm_wrap_lost", sm_cntr_lost, 0);
    sm_rx(4'd5, e);
    check("sm_gap1_err", e, 1);
    check("sm_gap1_lost", sm_cntr_lost, 4);
    sm_rx(4'd0, e);
    check("sm_gap2_lost", sm_cntr_lost, 14);
    sm_rx(4'd5, e);
    check("sm_sat1_lost", sm_cntr_lost, 15);
    sm_rx(4'd0, e);
    check("sm_sat2_err", e, 1);
    check("sm_sat2_lost", sm_cntr_lost, 15);
    check("sm_cntr_in", sm_cntr_in, 6);
    check("sm_no_output", sm_rx_m_valid, 0);

    // Final
    check("final_tx_q", tx_exp_q.size(), 0);
    check("final_rx_q", rx_exp_q.size(), 0);
    check("final_seq_errs", seen_err, m_err);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
